// File: rtl/bsg_fifo_1r1w_sync_mem_ctrl_pkg.sv
// Shared helpers for the sync-RAM FIFO controller slice.
package bsg_fifo_1r1w_sync_mem_ctrl_pkg;

  localparam int obuf_els_lp = 2;

  // Address/count width that never collapses to zero bits for tiny depths.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_sync_mem_ctrl_chk.sv
// Simulation-time protocol and invariant checks for the FIFO controller.
module bsg_fifo_1r1w_sync_mem_ctrl_chk #(
  parameter int els_p         = 4,
  parameter int addr_width_lp = 2,
  parameter int cnt_width_lp  = 3
) (
  input logic                     clk_i,
  input logic                     reset_n_i,
  input logic                     yumi_i,
  input logic                     v_o_i,
  input logic                     mem_w_v_i,
  input logic [addr_width_lp-1:0] mem_w_addr_i,
  input logic                     mem_r_v_i,
  input logic [addr_width_lp-1:0] mem_r_addr_i,
  input logic [cnt_width_lp-1:0]  ram_count_i
);

  yumi_legal_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    yumi_i |-> v_o_i);

  no_collision_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(mem_w_v_i && mem_r_v_i && (mem_w_addr_i == mem_r_addr_i)));

  count_bound_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    int'(ram_count_i) <= els_p);

endmodule

// File: rtl/bsg_fifo_1r1w_sync_mem_obuf.sv
// Two-entry in-order register FIFO that captures RAM read data and presents
// it as a valid/yumi stream; its occupancy feeds the read-credit logic.
module bsg_fifo_1r1w_sync_mem_obuf
  import bsg_fifo_1r1w_sync_mem_ctrl_pkg::*;
#(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               yumi_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  output logic [1:0]         count_o
);

  logic [width_p-1:0] slot0_q, slot1_q;
  logic               head_q, head_d;
  logic [1:0]         count_q, count_d;
  logic               tail;
  logic               deq;

  assign v_o     = (count_q != 2'd0);
  assign data_o  = head_q ? slot1_q : slot0_q;
  assign count_o = count_q;
  assign deq     = yumi_i & v_o;
  // When full, the tail aliases the head slot being freed by a same-cycle yumi.
  assign tail    = head_q ^ count_q[0];

  // Occupancy and head pointer next state.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    case ({v_i, deq})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (deq) head_d = ~head_q;
    else     head_d = head_q;
  end

  // Slot storage, head pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      slot0_q <= {width_p{1'b0}};
      slot1_q <= {width_p{1'b0}};
      head_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
      if (v_i && !tail) slot0_q <= data_i;
      if (v_i && tail)  slot1_q <= data_i;
    end
  end

endmodule

// File: rtl/bsg_fifo_1r1w_sync_mem_ctrl.sv
// FIFO controller around an external 1R1W synchronous-read RAM; a two-entry
// output buffer absorbs the RAM's one-cycle read latency.
module bsg_fifo_1r1w_sync_mem_ctrl
  import bsg_fifo_1r1w_sync_mem_ctrl_pkg::*;
#(
  parameter int width_p       = 8,
  parameter int els_p         = 4,
  parameter int addr_width_lp = safe_clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  input  logic [width_p-1:0]       data_i,
  output logic                     ready_o,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     yumi_i,
  output logic                     mem_w_v_o,
  output logic [addr_width_lp-1:0] mem_w_addr_o,
  output logic [width_p-1:0]       mem_w_data_o,
  output logic                     mem_r_v_o,
  output logic [addr_width_lp-1:0] mem_r_addr_o,
  input  logic [width_p-1:0]       mem_r_data_i
);

  localparam int cnt_width_lp = safe_clog2(els_p + 1);
  localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);
  localparam logic [addr_width_lp-1:0] addr_one_lp  = addr_width_lp'(1);
  localparam logic [cnt_width_lp-1:0]  full_cnt_lp  = cnt_width_lp'(els_p);
  localparam logic [cnt_width_lp-1:0]  cnt_one_lp   = cnt_width_lp'(1);

  logic [addr_width_lp-1:0] wptr_q, wptr_d;
  logic [addr_width_lp-1:0] rptr_q, rptr_d;
  logic [cnt_width_lp-1:0]  ram_count_q, ram_count_d;
  logic                     inflight_q;
  logic [1:0]               obuf_count;
  logic                     w_fire;
  logic                     r_fire;
  logic                     has_credit;

  assign ready_o    = reset_n_i & (ram_count_q != full_cnt_lp);
  assign w_fire     = v_i & ready_o;
  // A read may issue only if the obuf can take its data next cycle.
  assign has_credit = ({1'b0, obuf_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, yumi_i});
  assign r_fire     = reset_n_i & (ram_count_q != {cnt_width_lp{1'b0}}) & has_credit;

  assign mem_w_v_o    = w_fire;
  assign mem_w_addr_o = wptr_q;
  assign mem_w_data_o = data_i;
  assign mem_r_v_o    = r_fire;
  assign mem_r_addr_o = rptr_q;

  // Pointer wrap and RAM occupancy next state.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    ram_count_d = ram_count_q;
    if (w_fire) wptr_d = (wptr_q == last_addr_lp) ? {addr_width_lp{1'b0}} : wptr_q + addr_one_lp;
    else        wptr_d = wptr_q;
    if (r_fire) rptr_d = (rptr_q == last_addr_lp) ? {addr_width_lp{1'b0}} : rptr_q + addr_one_lp;
    else        rptr_d = rptr_q;
    case ({w_fire, r_fire})
      2'b10:   ram_count_d = ram_count_q + cnt_one_lp;
      2'b01:   ram_count_d = ram_count_q - cnt_one_lp;
      default: ram_count_d = ram_count_q;
    endcase
  end

  // Pointer, occupancy and read-in-flight registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q      <= {addr_width_lp{1'b0}};
      rptr_q      <= {addr_width_lp{1'b0}};
      ram_count_q <= {cnt_width_lp{1'b0}};
      inflight_q  <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      ram_count_q <= ram_count_d;
      inflight_q  <= r_fire;
    end
  end

  bsg_fifo_1r1w_sync_mem_obuf #(
    .width_p (width_p)
  ) obuf (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (inflight_q),
    .data_i    (mem_r_data_i),
    .yumi_i    (yumi_i),
    .v_o       (v_o),
    .data_o    (data_o),
    .count_o   (obuf_count)
  );

  bsg_fifo_1r1w_sync_mem_ctrl_chk #(
    .els_p         (els_p),
    .addr_width_lp (addr_width_lp),
    .cnt_width_lp  (cnt_width_lp)
  ) chk (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .yumi_i       (yumi_i),
    .v_o_i        (v_o),
    .mem_w_v_i    (mem_w_v_o),
    .mem_w_addr_i (mem_w_addr_o),
    .mem_r_v_i    (mem_r_v_o),
    .mem_r_addr_i (mem_r_addr_o),
    .ram_count_i  (ram_count_q)
  );

endmodule

// File: tb/tb_bsg_fifo_1r1w_sync_mem_ctrl.sv
// Bench for the sync-RAM FIFO controller: one instance with els_p=4, one with
// els_p=3, each beside a behavioural sync-read RAM; sel picks the active one.
module tb_bsg_fifo_1r1w_sync_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v, yumi, sel;
  logic [7:0] data;

  logic       a_ready, a_v_o, a_mw_v, a_mr_v;
  logic [7:0] a_data_o, a_mw_data, a_rdata;
  logic [1:0] a_mw_addr, a_mr_addr;
  logic       b_ready, b_v_o, b_mw_v, b_mr_v;
  logic [7:0] b_data_o, b_mw_data, b_rdata;
  logic [1:0] b_mw_addr, b_mr_addr;

  logic [7:0] ram_a [4];
  logic [7:0] ram_b [4];

  logic       ready, v_o, mw_v, mr_v;
  logic [7:0] data_o, mw_data;
  logic [1:0] mw_addr, mr_addr;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  bsg_fifo_1r1w_sync_mem_ctrl #(.width_p(8), .els_p(4)) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v & ~sel), .data_i(data), .ready_o(a_ready),
    .v_o(a_v_o), .data_o(a_data_o), .yumi_i(yumi & ~sel),
    .mem_w_v_o(a_mw_v), .mem_w_addr_o(a_mw_addr), .mem_w_data_o(a_mw_data),
    .mem_r_v_o(a_mr_v), .mem_r_addr_o(a_mr_addr), .mem_r_data_i(a_rdata));

  bsg_fifo_1r1w_sync_mem_ctrl #(.width_p(8), .els_p(3)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v & sel), .data_i(data), .ready_o(b_ready),
    .v_o(b_v_o), .data_o(b_data_o), .yumi_i(yumi & sel),
    .mem_w_v_o(b_mw_v), .mem_w_addr_o(b_mw_addr), .mem_w_data_o(b_mw_data),
    .mem_r_v_o(b_mr_v), .mem_r_addr_o(b_mr_addr), .mem_r_data_i(b_rdata));

  // Behavioural sync-read RAMs; read data is garbage unless a read was issued.
  always @(posedge clk) begin
    if (a_mw_v) ram_a[a_mw_addr] <= a_mw_data;
    a_rdata <= a_mr_v ? ram_a[a_mr_addr] : 8'($urandom);
    if (b_mw_v) ram_b[b_mw_addr] <= b_mw_data;
    b_rdata <= b_mr_v ? ram_b[b_mr_addr] : 8'($urandom);
  end

  assign ready   = sel ? b_ready   : a_ready;
  assign v_o     = sel ? b_v_o     : a_v_o;
  assign data_o  = sel ? b_data_o  : a_data_o;
  assign mw_v    = sel ? b_mw_v    : a_mw_v;
  assign mw_addr = sel ? b_mw_addr : a_mw_addr;
  assign mw_data = sel ? b_mw_data : a_mw_data;
  assign mr_v    = sel ? b_mr_v    : a_mr_v;
  assign mr_addr = sel ? b_mr_addr : a_mr_addr;

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    to_next(); to_next();
    v = 1'b1; data = 8'h11;
    #1;
    checks++;
    if (ready !== 1'b0 || v_o !== 1'b0 || mw_v !== 1'b0 || mr_v !== 1'b0) begin
      errors++; $display("FAIL reset_hold: ready=%b v_o=%b mw_v=%b mr_v=%b, expected all 0", ready, v_o, mw_v, mr_v);
    end
    checks++;
    if (mw_addr !== 2'd0 || mr_addr !== 2'd0) begin
      errors++; $display("FAIL reset_addr: w=%0d r=%0d, expected 0 0", mw_addr, mr_addr);
    end
    v = 1'b0; rst_n = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1 || v_o !== 1'b0) begin
      errors++; $display("FAIL reset_release: ready=%b v_o=%b, expected 1 0", ready, v_o);
    end
    to_next();
  endtask

  task automatic test_latency();
    sel = 1'b0; v = 1'b1; data = 8'hA5; yumi = 1'b0;
    #4;
    checks++;
    if (mw_v !== 1'b1 || mw_addr !== 2'd0 || mw_data !== 8'hA5) begin
      errors++; $display("FAIL lat_write: mw_v=%b addr=%0d data=%h, expected 1 0 a5", mw_v, mw_addr, mw_data);
    end
    to_next(); v = 1'b0; #4;
    checks++;
    if (mr_v !== 1'b1 || mr_addr !== 2'd0 || v_o !== 1'b0) begin
      errors++; $display("FAIL lat_read: mr_v=%b addr=%0d v_o=%b, expected 1 0 0", mr_v, mr_addr, v_o);
    end
    to_next(); #4;
    checks++;
    if (v_o !== 1'b0) begin
      errors++; $display("FAIL lat_cycle2: v_o=%b, expected 0", v_o);
    end
    to_next(); yumi = v_o; #4;
    checks++;
    if (v_o !== 1'b1 || data_o !== 8'hA5) begin
      errors++; $display("FAIL lat_out: v_o=%b data=%h, expected 1 a5", v_o, data_o);
    end
    to_next(); yumi = 1'b0; #4;
    checks++;
    if (v_o !== 1'b0) begin
      errors++; $display("FAIL lat_drained: v_o=%b, expected 0", v_o);
    end
    to_next();
  endtask

  task automatic test_fill();
    int nv = 1;
    int got = 0;
    int k = 0;
    sel = 1'b0; yumi = 1'b0;
    for (int c = 0; c < 20; c++) begin
      v = (nv <= 8); data = 8'(nv);
      #4;
      if (v && ready) nv++;
      to_next();
    end
    v = 1'b0; #4;
    checks++;
    if (nv - 1 != 6) begin
      errors++; $display("FAIL fill_accepted: got=%0d, expected 6", nv - 1);
    end
    checks++;
    if (ready !== 1'b0 || v_o !== 1'b1) begin
      errors++; $display("FAIL fill_full: ready=%b v_o=%b, expected 0 1", ready, v_o);
    end
    to_next();
    while (got < 6 && k < 30) begin
      yumi = v_o; #4;
      if (k == 0) begin
        checks++;
        if (ready !== 1'b0 || mr_v !== 1'b1) begin
          errors++; $display("FAIL fill_first_pop: ready=%b mr_v=%b, expected 0 1", ready, mr_v);
        end
      end
      if (k == 1) begin
        checks++;
        if (ready !== 1'b1) begin
          errors++; $display("FAIL fill_reready: ready=%b, expected 1", ready);
        end
      end
      if (yumi) begin
        checks++;
        if (data_o !== 8'(got + 1)) begin
          errors++; $display("FAIL fill_order: data=%0d, expected %0d", data_o, got + 1);
        end
        got++;
      end
      to_next(); k++;
    end
    yumi = 1'b0; #4;
    checks++;
    if (got != 6 || v_o !== 1'b0) begin
      errors++; $display("FAIL fill_drain: popped=%0d v_o=%b, expected 6 0", got, v_o);
    end
    to_next();
  endtask

  task automatic test_streaming();
    int pushed = 0;
    int popped = 0;
    sel = 1'b0;
    for (int c = 0; c < 106; c++) begin
      v = (pushed < 100); data = 8'(pushed); yumi = v_o;
      #4;
      checks++;
      if (v_o !== ((c >= 3) && (c < 103))) begin
        errors++; $display("FAIL stream_valid: cycle=%0d v_o=%b, expected %b", c, v_o, (c >= 3) && (c < 103));
      end
      if (v) begin
        checks++;
        if (ready !== 1'b1) begin
          errors++; $display("FAIL stream_ready: cycle=%0d ready=%b, expected 1", c, ready);
        end
        if (ready) pushed++;
      end
      if (yumi) begin
        checks++;
        if (data_o !== 8'(popped)) begin
          errors++; $display("FAIL stream_order: data=%0d, expected %0d", data_o, popped);
        end
        popped++;
      end
      to_next();
    end
    v = 1'b0; yumi = 1'b0;
    checks++;
    if (popped != 100) begin
      errors++; $display("FAIL stream_count: popped=%0d, expected 100", popped);
    end
  endtask

  task automatic test_wrap();
    int pushed = 0;
    int popped = 0;
    int wa = 0;
    int ra = 0;
    int c = 0;
    sel = 1'b1;
    exp_q.delete();
    while (popped < 10 && c < 300) begin
      v = (pushed < 10) && ($urandom_range(0, 1) == 1);
      data = 8'($urandom);
      yumi = v_o && ($urandom_range(0, 2) != 0);
      #4;
      if (mw_v) begin
        checks++;
        if (int'(mw_addr) != wa) begin
          errors++; $display("FAIL wrap_waddr: addr=%0d, expected %0d", mw_addr, wa);
        end
        wa = (wa == 2) ? 0 : wa + 1;
      end
      if (mr_v) begin
        checks++;
        if (int'(mr_addr) != ra) begin
          errors++; $display("FAIL wrap_raddr: addr=%0d, expected %0d", mr_addr, ra);
        end
        ra = (ra == 2) ? 0 : ra + 1;
      end
      if (v && ready) begin
        exp_q.push_back(data); pushed++;
      end
      if (yumi) begin
        checks++;
        if (exp_q.size() == 0 || data_o !== exp_q[0]) begin
          errors++; $display("FAIL wrap_order: data=%h, expected %h", data_o, (exp_q.size() != 0) ? exp_q[0] : 8'h00);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        popped++;
      end
      to_next(); c++;
    end
    v = 1'b0; yumi = 1'b0;
    checks++;
    if (popped != 10) begin
      errors++; $display("FAIL wrap_timeout: popped=%0d, expected 10", popped);
    end
  endtask

  task automatic test_stress();
    int occ;
    sel = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 10050; c++) begin
      v = (c < 10000) && ($urandom_range(0, 3) != 0);
      data = 8'($urandom);
      yumi = v_o && ((c >= 10000) || ($urandom_range(0, 3) != 0));
      #4;
      occ = exp_q.size();
      if (occ < 4) begin
        checks++;
        if (ready !== 1'b1) begin
          errors++; $display("FAIL stress_ready: occ=%0d ready=%b, expected 1", occ, ready);
        end
      end
      if (occ == 6) begin
        checks++;
        if (ready !== 1'b0) begin
          errors++; $display("FAIL stress_full: ready=%b, expected 0", ready);
        end
      end
      checks++;
      if (mw_v && mr_v && (mw_addr == mr_addr)) begin
        errors++; $display("FAIL stress_collision: addr=%0d, expected distinct", mw_addr);
      end
      if (v && ready) exp_q.push_back(data);
      if (yumi) begin
        checks++;
        if (occ == 0 || data_o !== exp_q[0]) begin
          errors++; $display("FAIL stress_order: data=%h occ=%0d", data_o, occ);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      to_next();
    end
    v = 1'b0; yumi = 1'b0; #4;
    checks++;
    if (exp_q.size() != 0 || v_o !== 1'b0) begin
      errors++; $display("FAIL stress_drain: left=%0d v_o=%b, expected 0 0", exp_q.size(), v_o);
    end
    to_next();
  endtask

  task automatic test_midstream_reset();
    sel = 1'b0; yumi = 1'b0;
    for (int c = 0; c < 5; c++) begin
      v = 1'b1; data = 8'(8'h40 + c);
      to_next();
    end
    checks++;
    if (v_o !== 1'b1) begin
      errors++; $display("FAIL mid_prefill: v_o=%b, expected 1", v_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (v_o !== 1'b0 || ready !== 1'b0 || mw_v !== 1'b0 || mr_v !== 1'b0) begin
      errors++; $display("FAIL mid_async: v_o=%b ready=%b mw_v=%b mr_v=%b, expected all 0", v_o, ready, mw_v, mr_v);
    end
    v = 1'b0;
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1 || v_o !== 1'b0) begin
      errors++; $display("FAIL mid_release: ready=%b v_o=%b, expected 1 0", ready, v_o);
    end
    for (int c = 0; c < 5; c++) begin
      to_next(); #4;
      checks++;
      if (v_o !== 1'b0 || mr_v !== 1'b0) begin
        errors++; $display("FAIL mid_empty: cycle=%0d v_o=%b mr_v=%b, expected 0 0", c, v_o, mr_v);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; v = 1'b0; yumi = 1'b0; sel = 1'b0; data = 8'h00;
    test_reset();
    test_latency();
    test_fill();
    test_streaming();
    test_wrap();
    test_stress();
    test_midstream_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
